// File: rtl/counter_sched.sv
// rtl/counter_sched.sv - round-robin scheduler sharing one down-counter among N one-shot timers (option: COUNTER_SCHED_ABORT_EN)
module counter_sched #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] delay,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   done,
    output logic           busy,
    output logic [W-1:0]   count
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [LW-1:0]  last;
    logic [LW-1:0]  last_nxt;
    logic [LW-1:0]  sel;
    logic           found;
    logic [N-1:0]   sel_onehot;
    logic [W-1:0]   sel_delay;
    logic [N-1:0]   grant_nxt;
    logic [W-1:0]   count_nxt;

    // Round-robin search: first set req bit starting just after the last owner
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= N; k++) begin
            if (!found && req[LW'((int'(last) + k) % N)]) begin
                found = 1'b1;
                sel   = LW'((int'(last) + k) % N);
            end
        end
    end

    // Decode the winner into a one-hot grant and pick out its delay slice
    always_comb begin
        sel_onehot = '0;
        sel_delay  = '0;
        for (int i = 0; i < N; i++) begin
            if (LW'(i) == sel) begin
                sel_onehot[i] = 1'b1;
                sel_delay     = delay[i*W +: W];
            end
        end
    end

    // Next-state logic: IDLE arbitrates, RUN counts down to zero, DONE releases
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        count_nxt = count;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = RUN;
                    grant_nxt = sel_onehot;
                    count_nxt = sel_delay;
                    last_nxt  = sel;
                end
            end
            RUN: begin
`ifdef COUNTER_SCHED_ABORT_EN
                // Owner withdrew its request: drop the job silently
                if (!(|(req & grant))) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    count_nxt = '0;
                end else
`endif
                if (count == '0) begin
                    state_nxt = DONE;
                end else begin
                    count_nxt = count - 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                count_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                count_nxt = '0;
            end
        endcase
    end

    // State, owner, counter and round-robin pointer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            count <= '0;
            last  <= LW'(N - 1);
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            count <= count_nxt;
            last  <= last_nxt;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE) ? grant : '0;

endmodule

// File: tb/tb_counter_sched.sv
// tb/tb_counter_sched.sv - self-checking bench for counter_sched
module tb_counter_sched;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] delay = '0;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           busy;
    logic [W-1:0]   count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [N-1:0]   req;
        logic [N*W-1:0] dly;
        int             owner;
        int             exp_count;
    } vec_t;

    typedef struct {
        logic [N-1:0] grant;
        logic [W-1:0] count;
        logic [N-1:0] done;
        logic         busy;
    } exp_t;

    vec_t vecs[8];
    exp_t exp_q[$];
    int   m_last;

    counter_sched #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .delay (delay),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .count (count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_done"},  32'(done),  32'h0);
        chk({tag, "_busy"},  32'(busy),  32'h0);
        chk({tag, "_count"}, 32'(count), 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // One complete job from an idle DUT: grant, countdown, done, back to idle
    task automatic run_vec(input vec_t v);
        logic [N-1:0] oh;
        oh    = N'(1) << v.owner;
        req   = v.req;
        delay = v.dly;
        @(negedge clk);
        chk("vec_grant", 32'(grant), 32'(oh));
        chk("vec_count0", 32'(count), 32'(v.exp_count));
        chk("vec_busy", 32'(busy), 32'h1);
        chk("vec_done_early", 32'(done), 32'h0);
        delay = $urandom;
        for (int j = 1; j <= v.exp_count; j++) begin
            @(negedge clk);
            chk("vec_count", 32'(count), 32'(v.exp_count - j));
            chk("vec_done_early", 32'(done), 32'h0);
        end
        @(negedge clk);
        chk("vec_done", 32'(done), 32'(oh));
        chk("vec_done_grant", 32'(grant), 32'(oh));
        chk("vec_done_count", 32'(count), 32'h0);
        req = '0;
        @(negedge clk);
        check_idle("vec_after");
    endtask

    initial begin
        int           ng;
        int           ndone;
        int           owners[$];
        int           cycles[$];
        logic [N-1:0] prev_grant;
        bit           hit;
        exp_t         cur;

        vecs[0] = '{4'b0010, 32'h00000300, 1, 3};
        vecs[1] = '{4'b0011, 32'h00000705, 0, 5};
        vecs[2] = '{4'b1001, 32'h04000002, 3, 4};
        vecs[3] = '{4'b0001, 32'h00000000, 0, 0};
        vecs[4] = '{4'b0110, 32'h00080100, 1, 1};
        vecs[5] = '{4'b0100, 32'h00080100, 2, 8};
        vecs[6] = '{4'b1000, 32'hFF000000, 3, 255};
        vecs[7] = '{4'b1111, 32'h00000002, 0, 2};

        // Reset state, then ten idle cycles
        @(negedge clk);
        check_idle("in_reset");
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_idle("idle");
        end

        // Table of single jobs; pointer carries from one entry to the next
        do_reset();
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Contention: all four held, delay 1 each
        do_reset();
        req        = 4'b1111;
        delay      = 32'h01010101;
        ng         = 0;
        ndone      = 0;
        prev_grant = '0;
        for (int c = 0; c < 40 && ng < 5; c++) begin
            @(negedge clk);
            if (done != 0) begin
                ndone++;
                chk("cont_done_owner", 32'(done), 32'(N'(1) << ((ng - 1) % N)));
            end
            if (grant != 0 && prev_grant == 0) begin
                for (int i = 0; i < N; i++) if (grant[i]) owners.push_back(i);
                cycles.push_back(c);
                ng++;
            end
            prev_grant = grant;
        end
        chk("cont_ngrants", 32'(ng), 32'd5);
        for (int i = 0; i < ng && i < owners.size(); i++)
            chk("cont_order", 32'(owners[i]), 32'(i % N));
        for (int i = 1; i < ng && i < cycles.size(); i++)
            chk("cont_spacing", 32'(cycles[i] - cycles[i-1]), 32'd4);
        chk("cont_ndone", 32'(ndone), 32'd4);
        req = '0;
        repeat (5) @(negedge clk);
        check_idle("cont_end");

        // Reset pulse while requester 2 is mid-run
        do_reset();
        req   = 4'b0100;
        delay = 32'h00090000;
        hit   = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            if (count == 8'd5 && grant == 4'b0100) hit = 1'b1;
        end
        chk("midrst_reach", 32'(hit), 32'h1);
        rst = 1'b0;
        req = '0;
        #1;
        check_idle("midrst_async");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("midrst_nodone", 32'(done), 32'h0);
            chk("midrst_nogrant", 32'(grant), 32'h0);
        end
        run_vec('{4'b0101, 32'h00030004, 0, 4});

        // Owner drops its request at count 2 with requester 3 pending
        do_reset();
        req   = 4'b1010;
        delay = 32'h02000600;
        @(negedge clk);
        chk("ab_grant1", 32'(grant), 32'h2);
        hit = 1'b0;
        for (int c = 0; c < 10 && !hit; c++) begin
            if (count == 8'd2) hit = 1'b1;
            else @(negedge clk);
        end
        chk("ab_reach", 32'(hit), 32'h1);
        req = 4'b1000;
`ifdef COUNTER_SCHED_ABORT_EN
        @(negedge clk);
        check_idle("ab_idle");
`else
        @(negedge clk);
        chk("ab_count1", 32'(count), 32'h1);
        @(negedge clk);
        chk("ab_count0", 32'(count), 32'h0);
        @(negedge clk);
        chk("ab_done1", 32'(done), 32'h2);
        @(negedge clk);
        check_idle("ab_gap");
`endif
        @(negedge clk);
        chk("ab_grant3", 32'(grant), 32'h8);
        chk("ab_count3", 32'(count), 32'h2);
        req = '0;
        repeat (6) @(negedge clk);
        check_idle("ab_end");

        // Randomized traffic against a job-level reference model
        do_reset();
        exp_q.delete();
        m_last = N - 1;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else cur = '{'0, '0, '0, 1'b0};
            chk("rnd_grant", 32'(grant), 32'(cur.grant));
            chk("rnd_count", 32'(count), 32'(cur.count));
            chk("rnd_done",  32'(done),  32'(cur.done));
            chk("rnd_busy",  32'(busy),  32'(cur.busy));
            for (int i = 0; i < N; i++) begin
                if (req[i] && cur.done[i]) req[i] = 1'($urandom_range(0, 1));
                else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
                delay[i*W +: W] = W'($urandom_range(0, 6));
            end
            if (!cur.busy && req != 0) begin
                int sel;
                int d;
                logic [N-1:0] oh;
                sel = -1;
                for (int k = 1; k <= N; k++)
                    if (sel < 0 && req[(m_last + k) % N]) sel = (m_last + k) % N;
                d  = int'(delay[sel*W +: W]);
                oh = N'(1) << sel;
                for (int j = 0; j <= d; j++) exp_q.push_back('{oh, W'(d - j), '0, 1'b1});
                exp_q.push_back('{oh, '0, oh, 1'b1});
                m_last = sel;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
